// File: rtl/beep_seq_pkg.sv
// Shared encoding and default timing for the beeper sequencer.
package beep_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam int NREQ_DEF     = 4;
   localparam int TICK_DIV_DEF = 50000;
   localparam int ON_MS_DEF    = 200;
   localparam int OFF_MS_DEF   = 100;
   localparam int GAP_MS_DEF   = 300;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed for a counter running 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/beep_tick_gen.sv
// Time-unit prescaler: counts 0..TICK_DIV-1, ticks on the last count,
// and restarts from zero whenever the sequencer enters a new state.
module beep_tick_gen
   import beep_seq_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int             CW   = cnt_w(TICK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_restart || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/beep_sequencer.sv
// Fixed-priority arbiter and burst sequencer driving the siren beeper enable.
//   state | meaning
//   IDLE  | no owner; grant lowest pending requester
//   ON    | beeper enabled for ON_MS units
//   OFF   | beeper silent for OFF_MS units between bursts
//   GAP   | post-sequence silence for GAP_MS units, grant held
module beep_sequencer
   import beep_seq_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int ON_MS    = ON_MS_DEF,
   parameter int OFF_MS   = OFF_MS_DEF,
   parameter int GAP_MS   = GAP_MS_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req,
   input  logic [4*NREQ-1:0] i_bursts,
   input  logic              i_abort,
   output logic              o_beep_en,
   output logic              o_busy,
   output logic [NREQ-1:0]   o_grant,
   output logic [NREQ-1:0]   o_pending,
   output logic              o_done
);

   localparam int                UNIT_W   = cnt_w(max3(ON_MS, OFF_MS, GAP_MS));
   localparam logic [UNIT_W-1:0] ON_LAST  = UNIT_W'(ON_MS - 1);
   localparam logic [UNIT_W-1:0] OFF_LAST = UNIT_W'(OFF_MS - 1);
   localparam logic [UNIT_W-1:0] GAP_LAST = UNIT_W'(GAP_MS - 1);

   state_t            r_state, w_state_nxt;
   logic [NREQ-1:0]   r_grant, w_grant_nxt;
   logic [NREQ-1:0]   r_pending, w_clr;
   logic [3:0]        r_rem, w_rem_nxt, w_sel;
   logic [UNIT_W-1:0] r_unit, w_unit_last;
   logic              r_done, w_done_nxt;
   logic              r_beep_en;
   logic              w_tick, w_restart, w_unit_done;

   beep_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // Any state change restarts the timebase, so every state lasts exactly K units.
   assign w_restart = (w_state_nxt != r_state);

   always_comb begin
      case (r_state)
         ST_ON:   w_unit_last = ON_LAST;
         ST_OFF:  w_unit_last = OFF_LAST;
         default: w_unit_last = GAP_LAST;
      endcase
   end

   assign w_unit_done = w_tick && (r_unit == w_unit_last);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_rem_nxt   = r_rem;
      w_clr       = '0;
      w_sel       = '0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_grant_nxt = '0;
            // Descending scan so the lowest set index is the one that sticks.
            for (int i = NREQ - 1; i >= 0; i--) begin
               if (r_pending[i]) begin
                  w_grant_nxt    = '0;
                  w_grant_nxt[i] = 1'b1;
                  w_sel          = i_bursts[4*i +: 4];
               end
            end
            if (|w_grant_nxt) begin
               w_state_nxt = ST_ON;
               w_clr       = w_grant_nxt;
               w_rem_nxt   = (w_sel == 4'd0) ? 4'd1 : w_sel;
            end
         end
         ST_ON: begin
            if (w_unit_done) begin
               if (r_rem > 4'd1) begin
                  w_rem_nxt   = r_rem - 4'd1;
                  w_state_nxt = ST_OFF;
               end else begin
                  w_state_nxt = ST_GAP;
               end
            end
         end
         ST_OFF: begin
            if (w_unit_done) begin
               w_state_nxt = ST_ON;
            end
         end
         ST_GAP: begin
            if (w_unit_done) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (i_abort) begin
         w_state_nxt = ST_IDLE;
         w_grant_nxt = '0;
         w_done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_pending <= '0;
         r_rem     <= '0;
         r_unit    <= '0;
         r_done    <= 1'b0;
         r_beep_en <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_rem     <= w_rem_nxt;
         r_done    <= w_done_nxt;
         r_beep_en <= (w_state_nxt == ST_ON);
         // A new request wins over the grant-time clear and replays later.
         r_pending <= i_abort ? '0 : ((r_pending & ~w_clr) | i_req);
         if (w_restart || (r_state == ST_IDLE)) begin
            r_unit <= '0;
         end else if (w_tick) begin
            r_unit <= r_unit + UNIT_W'(1);
         end
      end
   end

   assign o_beep_en = r_beep_en;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_grant   = r_grant;
   assign o_pending = r_pending;
   assign o_done    = r_done;

endmodule
